mul_arbiter: RTL and testbench

Shares one iterative 32×32 multiplier between `NREQ` requesters. Each request is granted round-robin and latched, then sequenced into the multiplier with a one-cycle start pulse. The block waits for completion, or for a watchdog timeout, and returns the 64-bit product tagged with the requester index over a valid/ready response channel. It sits between the client units and the multiplier datapath, which is driven only by this block.

---
 rtl/mul_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mul_arbiter.sv | 140 ++++++++++++++
 tb/tb_mul_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    localparam int OP_W_DEF    = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mul_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr_i, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
//
// Ports:
//   req_i      request vector
//   ptr_i      highest-priority index for this pick
//   gnt_o      one-hot grant (all-zero when no request)
//   gnt_idx_o  index of the granted requester
//   gnt_vld_o  at least one request is asserted
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_vld_o
);

    logic [IDW-1:0] scan_idx;
    logic           found;

    // Walk the requesters in priority order starting at ptr_i; the first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[scan_idx]) begin
                found            = 1'b1;
                gnt_o[scan_idx]  = 1'b1;
                gnt_idx_o        = scan_idx;
            end
        end
    end

    assign gnt_vld_o = |req_i;

endmodule

// File: rtl/mul_arbiter.sv
// Shares one iterative multiplier between NREQ requesters with round-robin grants.
// Latency: accept T -> mul_start T+1 -> response one cycle after mul_done (or watchdog expiry).
// Backpressure: one request in flight; req_ready stays low until the response is taken on rsp_ready.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              per-requester handshake (ready is one-hot, IDLE only)
//   req_a, req_b                     packed operands, slice [i*OP_W +: OP_W] per requester
//   rsp_valid/rsp_ready              response handshake
//   rsp_id, rsp_result, rsp_err      requester index, product, watchdog-timeout flag
//   mul_start, mul_a, mul_b          start pulse and latched operands to the multiplier
//   mul_done, mul_result             completion pulse and product from the multiplier
module mul_arbiter
    import mul_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int OP_W    = OP_W_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*OP_W-1:0]    rsp_result,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic                 mul_done,
    input  logic [2*OP_W-1:0]    mul_result
);

    // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    mul_arb_state_t      state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      id_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [2*OP_W-1:0]   result_q;
    logic                err_q;
    logic                start_q;
    logic                rsp_vld_q;
    logic [WD_W-1:0]     wd_q;

    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                gnt_vld;
    logic [IDW-1:0]      rr_ptr_d;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Ready is only offered in IDLE; gating with rst_n keeps it low while reset is held
    // even though the state register already reads IDLE.
    assign req_ready = (rst_n && (state_q == IDLE)) ? gnt : '0;

    // Next pointer is one past the winner so the winner drops to lowest priority.
    assign rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            rsp_vld_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        a_q      <= req_a[gnt_idx*OP_W +: OP_W];
                        b_q      <= req_b[gnt_idx*OP_W +: OP_W];
                        id_q     <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                        start_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over a watchdog expiring in the same cycle.
                    if (mul_done) begin
                        result_q  <= mul_result;
                        err_q     <= 1'b0;
                        rsp_vld_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (wd_q == WD_LAST) begin
                        result_q  <= '0;
                        err_q     <= 1'b1;
                        rsp_vld_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_vld_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign mul_start  = start_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier and reference model.
// Latency: n/a.
// Backpressure: exercised through rsp_ready hold-off.
module tb_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int OP_W    = 32;
    localparam int TIMEOUT = 64;
    localparam int IDW     = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [2*OP_W-1:0]    rsp_result;
    logic                 rsp_err;
    logic                 mul_start;
    logic [OP_W-1:0]      mul_a;
    logic [OP_W-1:0]      mul_b;
    logic                 mul_done;
    logic [2*OP_W-1:0]    mul_result;

    int n_chk  = 0;
    int n_pass = 0;
    int m_ptr  = 0;   // reference round-robin pointer

    always #5 clk = ~clk;

    mul_arbiter #(
        .NREQ    (NREQ),
        .OP_W    (OP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference arbitration: lowest rotated distance from the pointer wins.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        int r;
        r = -1;
        for (int o = NREQ - 1; o >= 0; o--)
            if (v[(p + o) % NREQ]) r = (p + o) % NREQ;
        return r;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Cycles from mul_start to rsp_valid for a done pulse lat cycles after start (-1: never).
    function automatic int exp_k(input int lat);
        return (lat >= 1 && lat <= TIMEOUT) ? lat + 1 : TIMEOUT + 1;
    endfunction

    // {err, product} expected from the operands and the multiplier's done timing.
    function automatic logic [2*OP_W:0] exp_rsp(input int lat, input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
        logic [2*OP_W-1:0] p;
        p = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
        return (lat >= 1 && lat <= TIMEOUT) ? {1'b0, p} : {1'b1, {2*OP_W{1'b0}}};
    endfunction

    // One full transaction: wait for a grant, act as the multiplier, collect the response.
    task automatic serve(input int lat, input int rdy_dly, input bit drop,
                         output int gid, output logic [OP_W-1:0] ga, output logic [OP_W-1:0] gb,
                         output logic [2*OP_W-1:0] res, output logic err, output int acc_wait);
        bit                hs;
        bit                seen;
        int                k;
        logic [IDW-1:0]    sid;
        logic [2*OP_W-1:0] sres;
        logic              serr;
        hs = 1'b0; seen = 1'b0; k = 0;
        gid = -1; ga = '0; gb = '0; res = '0; err = 1'b0; acc_wait = -1;
        for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge clk);
            check("idle_no_rsp", 128'(rsp_valid), 128'(0));
            if (req_ready != '0) begin
                hs       = 1'b1;
                acc_wait = c;
                gid      = idx_of(req_ready);
                check("grant", 128'(gid), 128'(pick(req_valid, m_ptr)));
                check("ready_onehot", 128'($countones(req_ready)), 128'(1));
                ga    = req_a[gid*OP_W +: OP_W];
                gb    = req_b[gid*OP_W +: OP_W];
                m_ptr = (gid + 1) % NREQ;
            end
            @(posedge clk); #1;
        end
        if (!hs) begin
            check("accept_timeout", 128'(0), 128'(1));
            return;
        end
        // Start cycle: the granted requester's operands are scrambled to prove they were latched.
        if (drop) req_valid[gid] = 1'b0;
        req_a[gid*OP_W +: OP_W] = $urandom;
        req_b[gid*OP_W +: OP_W] = $urandom;
        mul_done = 1'b0;
        @(negedge clk);
        check("start_pulse", 128'(mul_start), 128'(1));
        check("ops_latched", 128'({mul_a, mul_b}), 128'({ga, gb}));
        check("ready_busy", 128'(req_ready), 128'(0));
        while (!seen && k < 3 * TIMEOUT) begin
            @(posedge clk); #1;
            k++;
            mul_done   = (k == lat);
            mul_result = (k == lat) ? {{OP_W{1'b0}}, ga} * {{OP_W{1'b0}}, gb} : {$urandom, $urandom};
            @(negedge clk);
            if (k == 1) check("start_single", 128'(mul_start), 128'(0));
            seen = rsp_valid;
        end
        if (!seen) begin
            mul_done = 1'b0;
            check("rsp_timeout", 128'(0), 128'(1));
            return;
        end
        check("rsp_latency", 128'(k), 128'(exp_k(lat)));
        sid = rsp_id; sres = rsp_result; serr = rsp_err;
        check("rsp_id", 128'(sid), 128'(gid));
        check("ops_held", 128'({mul_a, mul_b}), 128'({ga, gb}));
        for (int h = 1; h <= rdy_dly + 1; h++) begin
            @(posedge clk); #1;
            k++;
            mul_done   = (k == lat);
            mul_result = (k == lat) ? {{OP_W{1'b0}}, ga} * {{OP_W{1'b0}}, gb} : {$urandom, $urandom};
            rsp_ready  = (h == rdy_dly + 1);
            @(negedge clk);
            check("rsp_hold", 128'({rsp_valid, rsp_id, rsp_result, rsp_err}),
                  128'({1'b1, sid, sres, serr}));
            check("ready_in_resp", 128'(req_ready), 128'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        mul_done  = 1'b0;
        res = sres;
        err = serr;
    endtask

    typedef struct {
        int                id;
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
        int                lat;
        int                rdy;
        logic [2*OP_W-1:0] exp_res;
        logic              exp_err;
    } vec_t;

    vec_t tv[8];

    initial begin
        int                gid;
        int                aw;
        int                lat;
        logic [OP_W-1:0]   ga;
        logic [OP_W-1:0]   gb;
        logic [2*OP_W-1:0] res;
        logic              err;
        logic [2*OP_W:0]   er;

        tv[0] = '{id: 2, a: 32'd7,          b: 32'd6,          lat: 33, rdy: 0,  exp_res: 64'd42,                exp_err: 1'b0};
        tv[1] = '{id: 0, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  lat: 64, rdy: 0,  exp_res: 64'hFFFFFFFE_00000001, exp_err: 1'b0};
        tv[2] = '{id: 3, a: 32'h0000_FFFF,  b: 32'h0001_0001,  lat: 2,  rdy: 10, exp_res: 64'h00000000_FFFFFFFF, exp_err: 1'b0};
        tv[3] = '{id: 1, a: 32'd5,          b: 32'd9,          lat: -1, rdy: 3,  exp_res: 64'd0,                 exp_err: 1'b1};
        tv[4] = '{id: 1, a: 32'd3,          b: 32'd3,          lat: 68, rdy: 6,  exp_res: 64'd0,                 exp_err: 1'b1};
        tv[5] = '{id: 0, a: 32'd1,          b: 32'h8000_0000,  lat: 63, rdy: 0,  exp_res: 64'h00000000_80000000, exp_err: 1'b0};
        tv[6] = '{id: 2, a: 32'h0001_0000,  b: 32'h0001_0000,  lat: 1,  rdy: 1,  exp_res: 64'h00000001_00000000, exp_err: 1'b0};
        tv[7] = '{id: 3, a: 32'hDEAD_BEEF,  b: 32'd2,          lat: 65, rdy: 0,  exp_res: 64'd0,                 exp_err: 1'b1};

        rst_n      = 1'b0;
        req_valid  = '1;
        req_a      = {$urandom, $urandom, $urandom, $urandom};
        req_b      = {$urandom, $urandom, $urandom, $urandom};
        rsp_ready  = 1'b0;
        mul_done   = 1'b0;
        mul_result = '0;

        // Reset state, with every requester asking.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp", 128'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err}), 128'(0));
        check("reset_mul", 128'({mul_start, mul_a, mul_b}), 128'(0));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = '0;
        m_ptr     = 0;

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            req_valid            = '0;
            req_valid[tv[i].id]  = 1'b1;
            req_a[tv[i].id*OP_W +: OP_W] = tv[i].a;
            req_b[tv[i].id*OP_W +: OP_W] = tv[i].b;
            serve(tv[i].lat, tv[i].rdy, 1'b1, gid, ga, gb, res, err, aw);
            req_valid = '0;
            check($sformatf("vec%0d_id", i), 128'(gid), 128'(tv[i].id));
            check($sformatf("vec%0d_res", i), 128'({res, err}), 128'({tv[i].exp_res, tv[i].exp_err}));
            check($sformatf("vec%0d_accept_wait", i), 128'(aw), 128'(0));
        end

        // Fairness: everyone asks continuously.
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            serve(1 + 3 * i, 0, 1'b0, gid, ga, gb, res, err, aw);
            check($sformatf("fair%0d_order", i), 128'(gid), 128'(i % NREQ));
            check($sformatf("fair%0d_res", i), 128'({err, res}), 128'(exp_rsp(1 + 3 * i, ga, gb)));
        end
        req_valid = '0;

        // Reset while a product is outstanding.
        req_valid = 4'b0010;
        req_a[1*OP_W +: OP_W] = 32'h1234_5678;
        req_b[1*OP_W +: OP_W] = 32'h0000_0003;
        @(negedge clk);
        check("mid_grant", 128'(req_ready), 128'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("mid_wait_ops", 128'({mul_a, rsp_valid}), 128'({32'h1234_5678, 1'b0}));
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        check("mid_reset_rsp", 128'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err}), 128'(0));
        check("mid_reset_mul", 128'({mul_start, mul_a, mul_b}), 128'(0));
        m_ptr = 0;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        req_valid  = '0;
        mul_done   = 1'b1;
        mul_result = 64'hABCD_0000_1234;
        @(posedge clk); #1;
        mul_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stray_done", 128'({rsp_valid, req_ready, mul_start}), 128'(0));
            @(posedge clk); #1;
        end
        req_valid = '1;
        serve(5, 0, 1'b1, gid, ga, gb, res, err, aw);
        req_valid = '0;
        check("post_reset_grant", 128'(gid), 128'(0));
        check("post_reset_res", 128'({err, res}), 128'(exp_rsp(5, ga, gb)));

        // Randomised traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int j = 0; j < NREQ; j++) begin
                req_a[j*OP_W +: OP_W] = $urandom;
                req_b[j*OP_W +: OP_W] = $urandom;
            end
            case ($urandom_range(0, 9))
                0:       lat = -1;
                1:       lat = $urandom_range(60, 70);
                default: lat = $urandom_range(1, 40);
            endcase
            serve(lat, $urandom_range(0, 3), 1'($urandom_range(0, 1)), gid, ga, gb, res, err, aw);
            er = exp_rsp(lat, ga, gb);
            check($sformatf("rnd%0d_res", i), 128'({err, res}), 128'(er));
        end
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
